// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - valid/ready byte handshake into the UART transmitter
// Signals:
//   uart_tx_data  : DATA_BITS payload, master -> slave
//   uart_tx_valid : payload valid, master -> slave
//   uart_tx_ready : holding register empty, slave -> master
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] uart_tx_data;
  logic                 uart_tx_valid;
  logic                 uart_tx_ready;

  modport master (output uart_tx_data, output uart_tx_valid, input uart_tx_ready);
  modport slave  (input uart_tx_data, input uart_tx_valid, output uart_tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (5-8 data bits, parity, 1/2 stop bits)
// Ports:
//   sys_clk       : system clock, rising edge
//   sys_rst       : synchronous active-high reset
//   tx            : uart_tx_cfg_if.slave, data/valid/ready handshake into a one-entry holding register
//   uart_tx_break : (only with UART_TX_BREAK_EN) hold the line low while idle
//   uart_tx_busy  : frame on the line (or break / break recovery active)
//   uart_tx_done  : one-cycle pulse on the last cycle of the last stop bit
//   uart_txd      : registered serial output, idle high
// Optional feature macro: UART_TX_BREAK_EN
module uart_tx_cfg #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BPS       = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  uart_tx_cfg_if.slave tx,
`ifdef UART_TX_BREAK_EN
  input  logic         uart_tx_break,
`endif
  output logic         uart_tx_busy,
  output logic         uart_tx_done,
  output logic         uart_txd
);

  localparam logic [31:0] BPS_CNT = 32'(CLK_FRE / BPS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLK_FRE / BPS < 2) begin : g_bad_bps_cnt
      $error("uart_tx_cfg: CLK_FRE / BPS must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic [31:0]          baud_cnt;
  logic [3:0]           bit_cnt;
  logic [0:0]           stop_cnt;

  logic baud_last, bit_last, stop_last, frame_end;
  logic load, txd_next, accept;
  logic brk_req, brk_now, rec_active;

`ifdef UART_TX_BREAK_EN
  logic rec;

  assign brk_req    = uart_tx_break;
  // Break only acts once the engine is idle; a frame in flight finishes first.
  assign brk_now    = uart_tx_break && (state == ST_IDLE);
  assign rec_active = rec;

  // After break release the line idles high for one full bit before a frame may start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rec <= 1'b0;
    end else if (brk_now) begin
      rec <= 1'b1;
    end else if (rec && baud_last) begin
      rec <= 1'b0;
    end
  end
`else
  assign brk_req    = 1'b0;
  assign brk_now    = 1'b0;
  assign rec_active = 1'b0;
`endif

  assign baud_last = (baud_cnt == BPS_CNT - 32'd1);
  assign bit_last  = (bit_cnt == 4'(DATA_BITS - 1));
  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end = (state == ST_STOP) && baud_last && stop_last;

  assign tx.uart_tx_ready = !hold_full && !brk_now;
  assign accept           = tx.uart_tx_valid && tx.uart_tx_ready;
  assign uart_tx_busy     = (state != ST_IDLE) || brk_now || rec_active;
  assign uart_tx_done     = frame_end;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // txd_next is the line value for the cycle after this edge, so it
  // anticipates the state transition taken on the same edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    txd_next   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (brk_now) begin
          txd_next = 1'b0;
        end else if (rec_active) begin
          txd_next = 1'b1;
        end else if (hold_full) begin
          load       = 1'b1;
          state_next = ST_START;
          txd_next   = 1'b0;
        end
      end
      ST_START: begin
        txd_next = 1'b0;
        if (baud_last) begin
          state_next = ST_DATA;
          txd_next   = shift_reg[0];
        end
      end
      ST_DATA: begin
        txd_next = shift_reg[0];
        if (baud_last) begin
          if (!bit_last) begin
            txd_next = shift_reg[1];
          end else if (PARITY != 0) begin
            state_next = ST_PARITY;
            txd_next   = par_bit;
          end else begin
            state_next = ST_STOP;
            txd_next   = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        txd_next = par_bit;
        if (baud_last) begin
          state_next = ST_STOP;
          txd_next   = 1'b1;
        end
      end
      ST_STOP: begin
        txd_next = 1'b1;
        if (frame_end) begin
          if (hold_full && !brk_req) begin
            // Queued byte: next start bit follows the stop bit with no gap.
            load       = 1'b1;
            state_next = ST_START;
            txd_next   = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      uart_txd  <= 1'b1;
    end else begin
      uart_txd <= txd_next;

      // accept needs an empty register and load needs a full one, so they never coincide.
      if (accept) begin
        hold_data <= tx.uart_tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift_reg <= hold_data;
        par_bit   <= (PARITY == 1) ? ~(^hold_data) : (^hold_data);
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= '0;
      end else if (state == ST_IDLE) begin
        // Idle only counts while timing the post-break recovery bit.
        baud_cnt <= (rec_active && !brk_now && !baud_last) ? baud_cnt + 32'd1 : '0;
      end else begin
        baud_cnt <= baud_last ? '0 : baud_cnt + 32'd1;
        if (state == ST_DATA && baud_last) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 4'd1;
        end
        if (state == ST_STOP && baud_last) begin
          stop_cnt <= stop_last ? '0 : stop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed bench for uart_tx_cfg (8N1, 8E1, 8O1, 5N2 instances)
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       valid;
  logic [7:0] data;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if3 ();

  assign if0.uart_tx_valid = valid && (sel == 2'd0);
  assign if1.uart_tx_valid = valid && (sel == 2'd1);
  assign if2.uart_tx_valid = valid && (sel == 2'd2);
  assign if3.uart_tx_valid = valid && (sel == 2'd3);
  assign if0.uart_tx_data  = data;
  assign if1.uart_tx_data  = data;
  assign if2.uart_tx_data  = data;
  assign if3.uart_tx_data  = data[4:0];

  logic [3:0] txd_v, busy_v, done_v, ready_v;
  assign ready_v = {if3.uart_tx_ready, if2.uart_tx_ready, if1.uart_tx_ready, if0.uart_tx_ready};

`ifdef UART_TX_BREAK_EN
  logic brk;
`endif

  uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .sys_rst(rst), .tx(if0.slave),
`ifdef UART_TX_BREAK_EN
    .uart_tx_break(brk),
`endif
    .uart_tx_busy(busy_v[0]), .uart_tx_done(done_v[0]), .uart_txd(txd_v[0]));
  uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .sys_clk(clk), .sys_rst(rst), .tx(if1.slave),
`ifdef UART_TX_BREAK_EN
    .uart_tx_break(1'b0),
`endif
    .uart_tx_busy(busy_v[1]), .uart_tx_done(done_v[1]), .uart_txd(txd_v[1]));
  uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .sys_clk(clk), .sys_rst(rst), .tx(if2.slave),
`ifdef UART_TX_BREAK_EN
    .uart_tx_break(1'b0),
`endif
    .uart_tx_busy(busy_v[2]), .uart_tx_done(done_v[2]), .uart_txd(txd_v[2]));
  uart_tx_cfg #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .sys_clk(clk), .sys_rst(rst), .tx(if3.slave),
`ifdef UART_TX_BREAK_EN
    .uart_tx_break(1'b0),
`endif
    .uart_tx_busy(busy_v[3]), .uart_tx_done(done_v[3]), .uart_txd(txd_v[3]));

  logic txd_m, busy_m, done_m, ready_m;
  assign txd_m   = txd_v[sel];
  assign busy_m  = busy_v[sel];
  assign done_m  = done_v[sel];
  assign ready_m = ready_v[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand a byte over and advance to the cycle where the start bit is on the line.
  task automatic send(input string tag, input logic [7:0] d);
    check({tag, "_rdy_hi"}, 32'(ready_m), 32'd1);
    valid = 1'b1;
    data  = d;
    step();
    valid = 1'b0;
    check({tag, "_rdy_lo"}, 32'(ready_m), 32'd0);
    check({tag, "_txd_pre"}, 32'(txd_m), 32'd1);
    step();
  endtask

  // seq[i] is the expected line level of bit time i (10 cycles each).
  task automatic run_frame(input string tag, input logic [31:0] seq, input int nbits,
                           input int frames, input int push_at, input logic [7:0] push_d,
                           input int ign_at);
    logic [9:0] samp;
    int n, ndone, first, last;
    n = nbits * 10;
    ndone = 0;
    first = -1;
    last = -1;
    samp = '0;
    for (int k = 0; k <= n; k++) begin
      if (k == push_at) begin
        valid = 1'b1;
        data  = push_d;
      end else if (k == push_at + 1) begin
        valid = 1'b0;
      end
      if (k == ign_at) begin
        check({tag, "_rdy_full"}, 32'(ready_m), 32'd0);
        valid = 1'b1;
        data  = 8'hFF;
      end else if (k == ign_at + 1) begin
        valid = 1'b0;
      end
      if (k == 0) check({tag, "_busy_hi"}, 32'(busy_m), 32'd1);
      if (k < n) begin
        samp[k % 10] = txd_m;
        if (k % 10 == 9)
          check($sformatf("%s_bit%0d", tag, k / 10), 32'(samp), seq[k / 10] ? 32'h3FF : 32'h0);
        if (done_m) begin
          ndone++;
          if (first < 0) first = k;
          last = k;
        end
      end else begin
        check({tag, "_busy_end"}, 32'(busy_m), 32'd0);
        check({tag, "_txd_end"}, 32'(txd_m), 32'd1);
        check({tag, "_done_end"}, 32'(done_m), 32'd0);
      end
      step();
    end
    check({tag, "_ndone"}, 32'(ndone), 32'(frames));
    check({tag, "_first_done"}, 32'(first), 32'(n / frames - 1));
    check({tag, "_last_done"}, 32'(last), 32'(n - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    sel   = 2'd0;
`ifdef UART_TX_BREAK_EN
    brk   = 1'b0;
`endif
    repeat (3) step();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst%0d_txd", s), 32'(txd_m), 32'd1);
      check($sformatf("rst%0d_ready", s), 32'(ready_m), 32'd1);
      check($sformatf("rst%0d_busy", s), 32'(busy_m), 32'd0);
      check($sformatf("rst%0d_done", s), 32'(done_m), 32'd0);
    end
    rst = 1'b0;
    sel = 2'd0;
    step();

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    sel = 2'd0;
    send("n1_55", 8'h55);
    run_frame("n1_55", 32'h2AA, 10, 1, -1, 8'h00, -1);

    // 0xA7 has five ones: even parity bit 1, odd parity bit 0
    sel = 2'd1;
    send("e1_a7", 8'hA7);
    run_frame("e1_a7", 32'h74E, 11, 1, -1, 8'h00, -1);
    sel = 2'd2;
    send("o1_a7", 8'hA7);
    run_frame("o1_a7", 32'h54E, 11, 1, -1, 8'h00, -1);

    // 5N2: five ones then two stop bits; upper input bits never reach the DUT
    sel = 2'd3;
    send("n2_1f", 8'hFF);
    run_frame("n2_1f", 32'h0FE, 8, 1, -1, 8'h00, -1);

    // Back-to-back 0x01 then 0x80, plus a valid pulse at ready=0 that must be dropped
    sel = 2'd0;
    send("b2b", 8'h01);
    run_frame("b2b", 32'hC0202, 20, 2, 20, 8'h80, 40);

    // Reset during data bit 3 of 0xF0, then a clean 0x3C frame
    sel = 2'd0;
    send("rst_f0", 8'hF0);
    repeat (45) step();
    rst = 1'b1;
    step();
    check("midrst_txd", 32'(txd_m), 32'd1);
    check("midrst_ready", 32'(ready_m), 32'd1);
    check("midrst_busy", 32'(busy_m), 32'd0);
    check("midrst_done", 32'(done_m), 32'd0);
    rst = 1'b0;
    send("post_3c", 8'h3C);
    run_frame("post_3c", 32'h278, 10, 1, -1, 8'h00, -1);

`ifdef UART_TX_BREAK_EN
    begin
      int ones;
      int highs;
      sel  = 2'd0;
      brk  = 1'b1;
      ones = 0;
      for (int i = 0; i < 50; i++) begin
        step();
        if (txd_m) ones++;
      end
      check("brk_txd_low", 32'(ones), 32'd0);
      check("brk_ready", 32'(ready_m), 32'd0);
      check("brk_busy", 32'(busy_m), 32'd1);
      brk = 1'b0;
      step();
      valid = 1'b1;
      data  = 8'hC3;
      highs = 0;
      for (int i = 0; i < 10; i++) begin
        if (txd_m) highs++;
        step();
        if (i == 0) valid = 1'b0;
      end
      check("brk_rec_high", 32'(highs), 32'd10);
      run_frame("brk_c3", 32'h386, 10, 1, -1, 8'h00, -1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
